uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 139 +++++++++++++
 tb/tb_uart_rx.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 asynchronous serial receiver.
//
// The receiver synchronizes rxd with two flops. It qualifies the start bit at
// its midpoint, then samples eight data bits LSB-first, one bit time apart.
// A byte is published only when the stop bit samples high. A low stop bit
// reports a framing error, and the FSM then waits for the line to return high
// so that a held-low break yields a single error.
//
// Ports
//   sysclk     in   system clock, all state changes on its rising edge
//   reset      in   asynchronous active-high reset
//   rxd        in   serial line (asynchronous to sysclk, idle high)
//   rx_data    out  last correctly framed byte
//   rx_status  out  one-cycle pulse when rx_data is updated
//   frame_err  out  one-cycle pulse when the stop bit is sampled low
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge on rxd_s
// START     | timing to mid start bit; a high level there is a glitch
// DATA      | sampling 8 data bits, one every CLKS_PER_BIT cycles
// STOP      | timing to mid stop bit; high publishes, low is a framing error
// WAIT_HIGH | after a framing error, hold until the line returns high

module uart_rx #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic       sysclk,
   input  logic       reset,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_status,
   output logic       frame_err
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_d;
   logic          status_d, ferr_d;
   logic          rxd_m, rxd_s;

   // Synchronizer flops reset high so that reset itself never looks like a start bit.
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         rxd_m <= 1'b1;
         rxd_s <= 1'b1;
      end else begin
         rxd_m <= rxd;
         rxd_s <= rxd_m;
      end
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         rx_data   <= '0;
         rx_status <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         rx_data   <= data_d;
         rx_status <= status_d;
         frame_err <= ferr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + CW'(1);
      idx_d    = idx_q;
      shift_d  = shift_q;
      data_d   = rx_data;
      status_d = 1'b0;
      ferr_d   = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (!rxd_s) state_d = START;
         end
         START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d   = '0;
               state_d = rxd_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d   = '0;
               shift_d = {rxd_s, shift_q[7:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d = '0;
               if (rxd_s) begin
                  data_d   = shift_q;
                  status_d = 1'b1;
                  state_d  = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            cnt_d = '0;
            if (rxd_s) state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- self-checking bench for uart_rx with a reduced bit time.
// Frames are driven at exactly CPB cycles per bit. A reference queue holds
// the bytes whose stop bit is high, together with the time of their start
// edge. Every rx_status pulse must match the head of that queue, both in
// value and in latency.

module tb_uart_rx;

   localparam int CPB = 16;
   localparam int HALF = CPB / 2;
   localparam int LAT = 2 + HALF + 9 * CPB;

   logic       sysclk = 1'b0;
   logic       reset  = 1'b1;
   logic       rxd    = 1'b1;
   logic [7:0] rx_data;
   logic       rx_status;
   logic       frame_err;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .sysclk    (sysclk),
      .reset     (reset),
      .rxd       (rxd),
      .rx_data   (rx_data),
      .rx_status (rx_status),
      .frame_err (frame_err)
   );

   always #5 sysclk = ~sysclk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   typedef struct {
      logic [7:0] data;
      longint     t_fall;
   } frame_t;

   frame_t     exp_q[$];
   logic [7:0] last_good = 8'h00;
   int         n_status  = 0;
   int         n_ferr    = 0;
   int         exp_status = 0;
   int         exp_ferr   = 0;
   logic       prev_status = 1'b0;
   logic       prev_ferr   = 1'b0;

   // Reference checks on every output pulse.
   always @(negedge sysclk) begin
      if (rx_status || frame_err)
         check("status_ferr_exclusive", {31'd0, rx_status & frame_err}, 32'd0);
      if (rx_status) begin
         frame_t f;
         longint diff;
         n_status++;
         check("status_one_cycle", {31'd0, prev_status}, 32'd0);
         if (exp_q.size() == 0) begin
            check("status_unexpected", 32'd1, 32'd0);
         end else begin
            f = exp_q.pop_front();
            check("rx_data", {24'd0, rx_data}, {24'd0, f.data});
            // Output rose at the previous posedge, 5 ns before this negedge.
            diff = ($time - 5) - f.t_fall - 10 * LAT;
            check("latency_tol", {31'd0, (diff >= -10 && diff <= 10)}, 32'd1);
            last_good = f.data;
         end
      end
      if (frame_err) begin
         n_ferr++;
         check("ferr_one_cycle", {31'd0, prev_ferr}, 32'd0);
         check("ferr_data_held", {24'd0, rx_data}, {24'd0, last_good});
      end
      prev_status = rx_status;
      prev_ferr   = frame_err;
   end

   task automatic line_bit(input logic v);
      rxd = v;
      repeat (CPB) @(negedge sysclk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_val);
      frame_t f;
      f.data   = d;
      f.t_fall = $time;
      if (stop_val) begin
         exp_q.push_back(f);
         exp_status++;
      end else begin
         exp_ferr++;
      end
      line_bit(1'b0);
      for (int i = 0; i < 8; i++) line_bit(d[i]);
      line_bit(stop_val);
   endtask

   task automatic settle_and_check(input string tag);
      rxd = 1'b1;
      repeat (2 * CPB) @(negedge sysclk);
      check({tag, "_status_cnt"}, n_status, exp_status);
      check({tag, "_ferr_cnt"}, n_ferr, exp_ferr);
      check({tag, "_pending"}, exp_q.size(), 0);
      check({tag, "_data_held"}, {24'd0, rx_data}, {24'd0, last_good});
   endtask

   initial begin
      repeat (3) @(negedge sysclk);
      check("reset_rx_data", {24'd0, rx_data}, 32'd0);
      check("reset_status", {31'd0, rx_status}, 32'd0);
      check("reset_ferr", {31'd0, frame_err}, 32'd0);
      reset = 1'b0;
      repeat (4) @(negedge sysclk);

      send_frame(8'h41, 1'b1);
      settle_and_check("single_41");

      send_frame(8'hBE, 1'b1);
      send_frame(8'hBF, 1'b1);
      settle_and_check("b2b_BE_BF");

      // Low pulse far shorter than half a bit
      rxd = 1'b0;
      repeat (HALF / 2) @(negedge sysclk);
      settle_and_check("glitch");

      // Bad stop followed by a long break, then a good frame
      send_frame(8'h55, 1'b0);
      repeat (5) line_bit(1'b0);
      line_bit(1'b1);
      settle_and_check("break");
      send_frame(8'h41, 1'b1);
      settle_and_check("after_break");

      // Reset in the middle of data bit 4
      line_bit(1'b0);
      for (int i = 0; i < 4; i++) line_bit(i == 0);
      rxd = 1'b0;
      repeat (HALF) @(negedge sysclk);
      reset = 1'b1;
      #1;
      check("midreset_rx_data", {24'd0, rx_data}, 32'd0);
      check("midreset_status", {31'd0, rx_status}, 32'd0);
      check("midreset_ferr", {31'd0, frame_err}, 32'd0);
      last_good = 8'h00;
      rxd = 1'b1;
      repeat (10) @(negedge sysclk);
      reset = 1'b0;
      repeat (2) @(negedge sysclk);
      settle_and_check("midreset");
      send_frame(8'h41, 1'b1);
      settle_and_check("after_reset");

      // Randomised frames, mixed gaps and occasional bad stop bits
      for (int n = 0; n < 40; n++) begin
         logic [7:0] d;
         logic       good;
         int         gap;
         d    = 8'($urandom_range(0, 255));
         good = ($urandom_range(0, 5) != 0);
         send_frame(d, good);
         gap = good ? $urandom_range(0, 2) : $urandom_range(1, 2);
         repeat (gap) line_bit(1'b1);
      end
      settle_and_check("random");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
